ws_frame_scheduler: RTL and testbench



---
 rtl/ws_frame_scheduler.sv | 224 ++++++++++++++++++++++
 tb/tb_ws_frame_scheduler.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : ws_frame_scheduler
//  Purpose  : Master-mode word-select generator and frame sequencer for the
//             I2S transceiver. Drives ws and the channel-slot state for the
//             shifter datapath. Requests one TX word per live slot, counts
//             slot bits, flags missing words and counts completed frames.
//  Ports    : clk        bit clock, one cycle per serial bit
//             rst        asynchronous active-high reset
//             start      begin framing (sampled in IDLE only)
//             stop       finish the current frame, then stop
//             stereo     1: L+R words per frame, 0: mono (L word only)
//             std_i2s    1: Philips I2S ws polarity, 0: left-justified
//             frame32    1: 32-bit slots, 0: 16-bit slots
//             word_ack   TX source supplied the requested word
//             ws         word-select line
//             ch_state   00 idle/dummy, 01 left, 10 right (live stereo word)
//             bit_idx    bit index within the slot, N-1 down to 0
//             word_req   one-cycle pulse at the first cycle of a live slot
//             underrun   sticky: a live slot ended without word_ack
//             busy       high in any non-idle state
//             frame_cnt  completed frames since the last start
//  Revision : 1.0 - initial release
// ============================================================================
module ws_frame_scheduler #(
    parameter int IDLE_GAP = 1,
    parameter int FCNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              stereo,
    input  logic              std_i2s,
    input  logic              frame32,
    input  logic              word_ack,
    output logic              ws,
    output logic [1:0]        ch_state,
    output logic [4:0]        bit_idx,
    output logic              word_req,
    output logic              underrun,
    output logic              busy,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int c_GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t              r_state,        w_state;
    logic                r_ws,           w_ws;
    logic [1:0]          r_ch_state,     w_ch_state;
    logic [4:0]          r_bit_idx,      w_bit_idx;
    logic                r_word_req,     w_word_req;
    logic                r_underrun,     w_underrun;
    logic                r_busy,         w_busy;
    logic [FCNT_W-1:0]   r_frame_cnt,    w_frame_cnt;
    logic                r_stop_pending, w_stop_pending;
    logic [c_GAP_W-1:0]  r_gap_cnt,      w_gap_cnt;
    logic                r_stereo,       w_stereo;
    logic                r_std_i2s,      w_std_i2s;
    logic                r_frame32,      w_frame32;
    logic                r_ack_seen,     w_ack_seen;

    logic [4:0]          w_slot_top;
    logic                w_slot_last;

    assign w_slot_top  = r_frame32 ? 5'd31 : 5'd15;
    assign w_slot_last = (r_bit_idx == 5'd0);

    // Level encoding: with I2S left=0/right=1/idle=1, with LJ left=1/right=0/
    // idle=0. Hence idle and right level equal std_i2s, left level is its
    // complement.
    always_comb begin
        w_state        = r_state;
        w_ws           = r_ws;
        w_ch_state     = r_ch_state;
        w_bit_idx      = r_bit_idx;
        w_word_req     = 1'b0;
        w_underrun     = r_underrun;
        w_frame_cnt    = r_frame_cnt;
        w_stop_pending = r_stop_pending;
        w_gap_cnt      = r_gap_cnt;
        w_stereo       = r_stereo;
        w_std_i2s      = r_std_i2s;
        w_frame32      = r_frame32;
        w_ack_seen     = r_ack_seen;

        case (r_state)
            ST_IDLE: begin
                // Idle ws follows the live polarity input, not the latched one.
                w_ws       = std_i2s;
                w_ch_state = 2'b00;
                w_bit_idx  = 5'd0;
                if (start && !stop) begin
                    w_state        = ST_LEFT;
                    w_stereo       = stereo;
                    w_std_i2s      = std_i2s;
                    w_frame32      = frame32;
                    w_underrun     = 1'b0;
                    w_frame_cnt    = '0;
                    w_stop_pending = 1'b0;
                    w_ack_seen     = 1'b0;
                    w_ws           = ~std_i2s;
                    w_ch_state     = 2'b01;
                    w_bit_idx      = frame32 ? 5'd31 : 5'd15;
                    w_word_req     = 1'b1;
                end
            end

            ST_LEFT: begin
                if (stop) w_stop_pending = 1'b1;
                if (word_ack) w_ack_seen = 1'b1;
                if (w_slot_last) begin
                    // The ack may arrive in the very last cycle of the slot.
                    if (!(r_ack_seen || word_ack)) w_underrun = 1'b1;
                    w_ack_seen = 1'b0;
                    w_state    = ST_RIGHT;
                    w_ws       = r_std_i2s;
                    w_ch_state = r_stereo ? 2'b10 : 2'b00;
                    w_bit_idx  = w_slot_top;
                    w_word_req = r_stereo;
                end else begin
                    w_bit_idx = r_bit_idx - 5'd1;
                end
            end

            ST_RIGHT: begin
                if (stop) w_stop_pending = 1'b1;
                // In mono the right half is a dummy slot: acks there are ignored.
                if (r_stereo && word_ack) w_ack_seen = 1'b1;
                if (w_slot_last) begin
                    if (r_stereo && !(r_ack_seen || word_ack)) w_underrun = 1'b1;
                    w_ack_seen  = 1'b0;
                    w_frame_cnt = r_frame_cnt + FCNT_W'(1);
                    // A stop arriving in this final cycle still ends the frame here.
                    if (r_stop_pending || stop) begin
                        w_state        = ST_GAP;
                        w_stop_pending = 1'b0;
                        w_ws           = r_std_i2s;
                        w_ch_state     = 2'b00;
                        w_bit_idx      = 5'd0;
                        w_gap_cnt      = c_GAP_W'(IDLE_GAP - 1);
                    end else begin
                        w_state    = ST_LEFT;
                        w_ws       = ~r_std_i2s;
                        w_ch_state = 2'b01;
                        w_bit_idx  = w_slot_top;
                        w_word_req = 1'b1;
                    end
                end else begin
                    w_bit_idx = r_bit_idx - 5'd1;
                end
            end

            ST_GAP: begin
                w_ch_state     = 2'b00;
                w_bit_idx      = 5'd0;
                w_stop_pending = 1'b0;
                if (r_gap_cnt == '0) begin
                    w_state = ST_IDLE;
                    w_ws    = std_i2s;
                end else begin
                    w_gap_cnt = r_gap_cnt - c_GAP_W'(1);
                end
            end

            default: begin
                w_state = ST_IDLE;
            end
        endcase

        w_busy = (w_state != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_ws           <= 1'b1;
            r_ch_state     <= 2'b00;
            r_bit_idx      <= 5'd0;
            r_word_req     <= 1'b0;
            r_underrun     <= 1'b0;
            r_busy         <= 1'b0;
            r_frame_cnt    <= '0;
            r_stop_pending <= 1'b0;
            r_gap_cnt      <= '0;
            r_stereo       <= 1'b0;
            r_std_i2s      <= 1'b0;
            r_frame32      <= 1'b0;
            r_ack_seen     <= 1'b0;
        end else begin
            r_state        <= w_state;
            r_ws           <= w_ws;
            r_ch_state     <= w_ch_state;
            r_bit_idx      <= w_bit_idx;
            r_word_req     <= w_word_req;
            r_underrun     <= w_underrun;
            r_busy         <= w_busy;
            r_frame_cnt    <= w_frame_cnt;
            r_stop_pending <= w_stop_pending;
            r_gap_cnt      <= w_gap_cnt;
            r_stereo       <= w_stereo;
            r_std_i2s      <= w_std_i2s;
            r_frame32      <= w_frame32;
            r_ack_seen     <= w_ack_seen;
        end
    end

    assign ws        = r_ws;
    assign ch_state  = r_ch_state;
    assign bit_idx   = r_bit_idx;
    assign word_req  = r_word_req;
    assign underrun  = r_underrun;
    assign busy      = r_busy;
    assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ws_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ws_frame_scheduler
//  Purpose  : Self-checking bench for ws_frame_scheduler. A reference model
//             derives every expected output from the cycle offset since start
//             (slot = offset mod frame length), the latched configuration and
//             the recorded stop/ack history.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ws_frame_scheduler;

    localparam int IDLE_GAP = 2;
    localparam int FCNT_W   = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start, stop, stereo, std_i2s, frame32, word_ack;
    logic              ws;
    logic [1:0]        ch_state;
    logic [4:0]        bit_idx;
    logic              word_req, underrun, busy;
    logic [FCNT_W-1:0] frame_cnt;

    ws_frame_scheduler #(.IDLE_GAP(IDLE_GAP), .FCNT_W(FCNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .stereo(stereo),
        .std_i2s(std_i2s), .frame32(frame32), .word_ack(word_ack),
        .ws(ws), .ch_state(ch_state), .bit_idx(bit_idx), .word_req(word_req),
        .underrun(underrun), .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    int   m_phase;      // 0 idle, 1 framing, 2 gap
    int   m_k;          // cycle offset since start of the cycle now shown
    int   m_n;          // slot length
    int   m_end;        // number of frames to run, -1 while no stop seen
    int   m_gap_left;
    bit   m_stereo, m_i2s, m_ack_seen;

    logic              e_ws, e_wr, e_ur, e_busy;
    logic [1:0]        e_ch;
    logic [4:0]        e_bit;
    logic [FCNT_W-1:0] e_cnt;

    logic [26:0] obs_vec, exp_vec;
    assign obs_vec = {ws, ch_state, bit_idx, word_req, underrun, busy, frame_cnt};
    assign exp_vec = {e_ws, e_ch, e_bit, e_wr, e_ur, e_busy, e_cnt};

    task automatic model_reset();
        m_phase = 0; m_k = 0; m_n = 16; m_end = -1; m_gap_left = 0;
        m_stereo = 0; m_i2s = 0; m_ack_seen = 0;
        e_ws = 1'b1; e_ch = 2'd0; e_bit = 5'd0; e_wr = 1'b0;
        e_ur = 1'b0; e_busy = 1'b0; e_cnt = '0;
    endtask

    // Called at each active edge with the inputs the DUT samples there.
    task automatic model_edge();
        int f, pos;
        bit live;
        if (m_phase == 0) begin
            if (start && !stop) begin
                m_phase = 1; m_n = frame32 ? 32 : 16; m_stereo = stereo;
                m_i2s = std_i2s; m_k = 0; m_end = -1; e_ur = 1'b0; m_ack_seen = 0;
            end
        end else if (m_phase == 1) begin
            f = 2 * m_n; pos = m_k % f;
            live = (pos < m_n) || m_stereo;
            if (live && word_ack) m_ack_seen = 1;
            if ((pos % m_n) == m_n - 1) begin
                if (live && !m_ack_seen) e_ur = 1'b1;
                m_ack_seen = 0;
            end
            if (stop && m_end < 0) m_end = m_k / f + 1;
            m_k++;
            if (m_end >= 0 && m_k == m_end * f) begin
                m_phase = 2; m_gap_left = IDLE_GAP;
            end
        end else begin
            m_gap_left--;
            if (m_gap_left == 0) m_phase = 0;
        end

        e_wr = 1'b0;
        if (m_phase == 0) begin
            e_ws = std_i2s;  // idle level: 1 for I2S, 0 for LJ
            e_ch = 2'd0; e_bit = 5'd0; e_busy = 1'b0;
        end else if (m_phase == 1) begin
            f = 2 * m_n; pos = m_k % f;
            if (pos < m_n) e_ws = m_i2s ? 1'b0 : 1'b1;   // left level
            else           e_ws = m_i2s ? 1'b1 : 1'b0;   // right level
            e_ch   = (pos < m_n) ? 2'd1 : (m_stereo ? 2'd2 : 2'd0);
            e_bit  = 5'(m_n - 1 - (pos % m_n));
            e_wr   = (pos == 0) || (m_stereo && pos == m_n);
            e_busy = 1'b1;
            e_cnt  = FCNT_W'(m_k / f);
        end else begin
            e_ws = m_i2s ? 1'b1 : 1'b0;
            e_ch = 2'd0; e_bit = 5'd0; e_busy = 1'b1;
            e_cnt = FCNT_W'(m_end);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; start = 0; stop = 0; stereo = 0; std_i2s = 1; frame32 = 0; word_ack = 0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (obs_vec !== 27'h4000000) begin
            n_err++;
            $display("FAIL reset_values got=%h want=%h", obs_vec, 27'h4000000);
        end
        @(negedge clk) rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            std_i2s = 1'(i & 1);
            tick();
            n_vec++;
            if (obs_vec !== exp_vec) begin
                n_err++;
                $display("FAIL reset_idle i=%0d got=%h want=%h", i, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_i2s_stereo16();
        int k;
        std_i2s = 1; stereo = 1; frame32 = 0; word_ack = 1; stop = 0;
        tick();
        start = 1;
        tick();
        start = 0;
        n_vec++;
        if (ws !== 1'b0 || word_req !== 1'b1) begin
            n_err++;
            $display("FAIL i2s_first_cycle ws=%b wr=%b want ws=0 wr=1", ws, word_req);
        end
        k = 0;
        while (e_busy && k < 400) begin
            stop = (k == 70);
            word_ack = ($urandom_range(0, 3) != 0);
            tick();
            k++;
            n_vec++;
            if (obs_vec !== exp_vec) begin
                n_err++;
                $display("FAIL i2s_stereo16 k=%0d got=%h want=%h", k, obs_vec, exp_vec);
            end
            if (k == 16 && word_req !== 1'b1) begin
                n_err++;
                $display("FAIL i2s_r_word_req got=%b want=1", word_req);
            end
            if (k == 32 && frame_cnt !== 16'd1) begin
                n_err++;
                $display("FAIL i2s_frame_cnt got=%0d want=1", frame_cnt);
            end
        end
        stop = 0;
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL i2s_drain busy=%b want 0", busy);
        end
    endtask

    task automatic test_lj_mono32();
        int k, reqs;
        std_i2s = 0; stereo = 0; frame32 = 1; word_ack = 1; stop = 0;
        tick();
        n_vec++;
        if (ws !== 1'b0) begin
            n_err++;
            $display("FAIL lj_idle_ws got=%b want=0", ws);
        end
        start = 1;
        tick();
        start = 0;
        reqs = word_req ? 1 : 0;
        k = 0;
        while (e_busy && k < 400) begin
            stop = (k == 127);
            tick();
            k++;
            if (k < 128 && word_req) reqs++;
            n_vec++;
            if (obs_vec !== exp_vec) begin
                n_err++;
                $display("FAIL lj_mono32 k=%0d got=%h want=%h", k, obs_vec, exp_vec);
            end
        end
        stop = 0;
        n_vec++;
        if (reqs !== 2) begin
            n_err++;
            $display("FAIL lj_mono_reqs got=%0d want=2", reqs);
        end
    endtask

    task automatic test_stop_gap();
        int k, f, gaps;
        std_i2s = 1'($urandom_range(0, 1)); stereo = 1'($urandom_range(0, 1));
        frame32 = 1'($urandom_range(0, 1)); word_ack = 1; stop = 0;
        start = 1;
        tick();
        start = 0;
        f = 2 * m_n; k = 0; gaps = 0;
        while (e_busy && k < 1000) begin
            stop = (k == 2 * f + m_n / 2);
            tick();
            k++;
            if (k >= 3 * f && busy === 1'b1) gaps++;
            n_vec++;
            if (obs_vec !== exp_vec) begin
                n_err++;
                $display("FAIL stop_gap k=%0d got=%h want=%h", k, obs_vec, exp_vec);
            end
        end
        stop = 0;
        n_vec++;
        if (frame_cnt !== 16'd3 || gaps !== IDLE_GAP) begin
            n_err++;
            $display("FAIL stop_gap_end cnt=%0d gap=%0d want cnt=3 gap=%0d", frame_cnt, gaps, IDLE_GAP);
        end
    endtask

    task automatic test_underrun();
        int k;
        std_i2s = 1'($urandom_range(0, 1)); stereo = 1; frame32 = 0; stop = 0; word_ack = 1;
        start = 1;
        tick();
        start = 0;
        k = 0;
        while (e_busy && k < 400) begin
            word_ack = !(k >= 16 && k < 32);
            stop = (k == 40);
            tick();
            k++;
            n_vec++;
            if (obs_vec !== exp_vec) begin
                n_err++;
                $display("FAIL underrun k=%0d got=%h want=%h", k, obs_vec, exp_vec);
            end
            if ((k == 31 && underrun !== 1'b0) || (k == 32 && underrun !== 1'b1)) begin
                n_err++;
                $display("FAIL underrun_edge k=%0d got=%b want=%b", k, underrun, k == 32);
            end
        end
        stop = 0; word_ack = 1;
        n_vec++;
        if (underrun !== 1'b1) begin
            n_err++;
            $display("FAIL underrun_sticky got=%b want=1", underrun);
        end
        start = 1;
        tick();
        start = 0;
        n_vec++;
        if (underrun !== 1'b0 || obs_vec !== exp_vec) begin
            n_err++;
            $display("FAIL underrun_clear got=%h want=%h", obs_vec, exp_vec);
        end
        stop = 1;
        tick();
        stop = 0;
        k = 0;
        while (e_busy && k < 400) begin
            tick();
            k++;
            n_vec++;
            if (obs_vec !== exp_vec) begin
                n_err++;
                $display("FAIL underrun_drain k=%0d got=%h want=%h", k, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_reset_mid();
        std_i2s = 0; stereo = 1; frame32 = 0; word_ack = 1; stop = 0;
        start = 1;
        tick();
        start = 0;
        repeat (20) tick();
        n_vec++;
        if (ch_state !== 2'b10 || obs_vec !== exp_vec) begin
            n_err++;
            $display("FAIL reset_mid_pre got=%h want=%h", obs_vec, exp_vec);
        end
        #2 rst = 1'b1;
        #1;
        model_reset();
        n_vec++;
        if (obs_vec !== 27'h4000000) begin
            n_err++;
            $display("FAIL reset_mid_async got=%h want=%h", obs_vec, 27'h4000000);
        end
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            std_i2s = 1'($urandom_range(0, 1));
            stop = 1'($urandom_range(0, 1));
            tick();
            n_vec++;
            if (obs_vec !== exp_vec || busy !== 1'b0) begin
                n_err++;
                $display("FAIL reset_mid_quiet i=%0d got=%h want=%h", i, obs_vec, exp_vec);
            end
        end
        stop = 0;
    endtask

    task automatic test_start_stop_cfg();
        int k;
        start = 1; stop = 1;
        tick();
        start = 0; stop = 0;
        n_vec++;
        if (busy !== 1'b0 || ch_state !== 2'b00) begin
            n_err++;
            $display("FAIL start_stop_together busy=%b ch=%b want 0/00", busy, ch_state);
        end
        for (int r = 0; r < 6; r++) begin
            std_i2s = 1'($urandom_range(0, 1)); stereo = 1'($urandom_range(0, 1));
            frame32 = 1'($urandom_range(0, 1)); word_ack = 1;
            start = 1;
            tick();
            start = 0;
            k = 0;
            while (e_busy && k < 600) begin
                std_i2s  = 1'($urandom_range(0, 1));
                stereo   = 1'($urandom_range(0, 1));
                frame32  = 1'($urandom_range(0, 1));
                word_ack = ($urandom_range(0, 15) != 0);
                stop     = ($urandom_range(0, 60) == 0) || (k > 4 * 2 * m_n);
                tick();
                k++;
                n_vec++;
                if (obs_vec !== exp_vec) begin
                    n_err++;
                    $display("FAIL cfg_random r=%0d k=%0d got=%h want=%h", r, k, obs_vec, exp_vec);
                end
            end
            stop = 0;
            n_vec++;
            if (e_busy) begin
                n_err++;
                $display("FAIL cfg_random_timeout r=%0d busy=%b want 0", r, busy);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_i2s_stereo16();
        test_lj_mono32();
        test_stop_gap();
        test_underrun();
        test_reset_mid();
        test_start_stop_cfg();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
